// File: rtl/oven_ctrl.sv
// Oven controller: hysteresis heater control with an in-band cook timer.
// Ports: clk, rst_n, start/stop levels, current_temp/set_temp, set_time in;
//        heater, panel LEDs, done, time_left out.
module oven_ctrl #(
    parameter int TEMP_W   = 8,
    parameter int TIME_W   = 8,
    parameter int BAND     = 10,
    parameter int TICK_DIV = 1000,
    parameter int MAX_TEMP = 250
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic [TEMP_W-1:0] current_temp,
    input  logic [TEMP_W-1:0] set_temp,
    input  logic [TIME_W-1:0] set_time,
    output logic              heater,
    output logic              led_stop,
    output logic              led_start,
    output logic              led_high,
    output logic              led_set,
    output logic              led_low,
    output logic              led_fault,
    output logic              done,
    output logic [TIME_W-1:0] time_left
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOW   = 3'd1,
        S_SET   = 3'd2,
        S_HIGH  = 3'd3,
        S_DONE  = 3'd4,
        S_FAULT = 3'd5
    } state_t;

    localparam int TW1 = TEMP_W + 1;
    localparam int PW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [TEMP_W:0] BAND_X = TW1'(BAND);
    localparam logic [TEMP_W:0] MAX_X  = TW1'(MAX_TEMP);
    localparam logic [TEMP_W:0] T_SAT  = {1'b0, {TEMP_W{1'b1}}};
    localparam logic [PW-1:0]   P_LAST = PW'(TICK_DIV - 1);

    state_t            state, state_nxt;
    logic [PW-1:0]     presc, presc_nxt;
    logic [TIME_W-1:0] tl_nxt;

    logic [TEMP_W:0] temp_x, set_x, upper_raw, upper, lower;
    logic            active, in_band, over, tick, go, last;

    // Limits carry one extra bit so the saturation checks can see overflow.
    assign temp_x    = {1'b0, current_temp};
    assign set_x     = {1'b0, set_temp};
    assign upper_raw = set_x + BAND_X;
    assign upper     = (upper_raw > T_SAT) ? T_SAT : upper_raw;
    assign lower     = (set_x > BAND_X) ? (set_x - BAND_X) : '0;

    assign active  = (state == S_LOW) || (state == S_SET) || (state == S_HIGH);
    assign in_band = (state == S_SET) || (state == S_HIGH);
    assign over    = temp_x >= MAX_X;
    assign tick    = in_band && (presc == P_LAST);
    assign last    = tick && (time_left == TIME_W'(1));
    assign go      = ((state == S_IDLE) || (state == S_DONE)) && start
                     && (set_time != '0);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next state: stop > fault > expiry > start > temperature
    always_comb begin
        state_nxt = state;
        if (stop) begin
            state_nxt = S_IDLE;
        end else if (active && over) begin
            state_nxt = S_FAULT;
        end else if (last) begin
            state_nxt = S_DONE;
        end else if (go) begin
            state_nxt = S_LOW;
        end else begin
            case (state)
                S_LOW:   if (temp_x > lower) state_nxt = S_SET;
                S_SET: begin
                    if (temp_x >= upper)      state_nxt = S_HIGH;
                    else if (temp_x <= lower) state_nxt = S_LOW;
                end
                S_HIGH:  if (temp_x < upper) state_nxt = S_SET;
                default: state_nxt = state;
            endcase
        end
    end

    // Prescaler runs only in band, freezes while heating back up.
    always_comb begin
        presc_nxt = '0;
        if (in_band)             presc_nxt = tick ? '0 : presc + PW'(1);
        else if (state == S_LOW) presc_nxt = presc;
    end

    always_comb begin
        tl_nxt = time_left;
        if (stop)
            tl_nxt = '0;
        else if (active && over)
            tl_nxt = time_left;
        else if (tick && (time_left != '0))
            tl_nxt = time_left - TIME_W'(1);
        else if (go)
            tl_nxt = set_time;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc     <= '0;
            time_left <= '0;
        end else begin
            presc     <= presc_nxt;
            time_left <= tl_nxt;
        end
    end

    // Output decode
    always_comb begin
        heater    = (state == S_LOW) && !over;
        led_stop  = stop;
        led_start = active;
        led_low   = (state == S_LOW);
        led_set   = (state == S_SET);
        led_high  = (state == S_HIGH);
        led_fault = (state == S_FAULT);
        done      = (state == S_DONE);
    end

endmodule

// File: tb/tb_oven_ctrl.sv
// Testbench for oven_ctrl: directed vector table, async reset sequence,
// and randomized run against a cycle-count reference model.
module tb_oven_ctrl;

    localparam int ML = 1, MS = 2, MH = 3, MD = 4, MF = 5, MI = 0;
    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, stop = 1'b0;
    logic [7:0] current_temp = '0, set_temp = '0, set_time = '0;
    logic       heater, led_stop, led_start, led_high, led_set;
    logic       led_low, led_fault, done;
    logic [7:0] time_left;

    int n_tests = 0;
    int n_fail  = 0;

    oven_ctrl #(
        .TEMP_W(8), .TIME_W(8), .BAND(10), .TICK_DIV(DIV), .MAX_TEMP(250)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .current_temp(current_temp), .set_temp(set_temp),
        .set_time(set_time), .heater(heater), .led_stop(led_stop),
        .led_start(led_start), .led_high(led_high), .led_set(led_set),
        .led_low(led_low), .led_fault(led_fault), .done(done),
        .time_left(time_left)
    );

    always #5 clk = ~clk;

    wire [15:0] obs = {heater, led_stop, led_start, led_high, led_set,
                       led_low, led_fault, done, time_left};

    function automatic logic [15:0] exp_out(int mode, int tl, logic stp,
                                            int temp);
        logic h;
        h = (mode == ML) && (temp < 250);
        return {h, stp, (mode == ML || mode == MS || mode == MH),
                mode == MH, mode == MS, mode == ML, mode == MF, mode == MD,
                8'(tl)};
    endfunction

    task automatic check(string nm, logic [15:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, obs, exp);
        end
    endtask

    typedef struct {
        logic st;
        logic sp;
        int   temp;
        int   stemp;
        int   stime;
        int   mode;
        int   tl;
    } vec_t;

    vec_t tv[$];

    function automatic void add(int n, logic st, logic sp, int temp,
                                int stemp, int stime, int mode, int tl);
        vec_t v;
        v.st = st; v.sp = sp; v.temp = temp; v.stemp = stemp;
        v.stime = stime; v.mode = mode; v.tl = tl;
        for (int k = 0; k < n; k++) tv.push_back(v);
    endfunction

    task automatic drive(logic st, logic sp, int temp, int stemp,
                         int stime);
        start        = st;
        stop         = sp;
        current_temp = 8'(temp);
        set_temp     = 8'(stemp);
        set_time     = 8'(stime);
    endtask

    // Reference model: progress is counted in in-band clock cycles;
    // remaining time is the loaded time minus whole elapsed units.
    int m_mode = MI, m_loaded = 0, m_inband = 0;

    function automatic int m_tl();
        return (m_mode == MI) ? 0 : m_loaded - m_inband / DIV;
    endfunction

    function automatic void m_step(logic st, logic sp, int temp, int stemp,
                                   int stime);
        int up, lo;
        bit act, band;
        up   = (stemp + 10 > 255) ? 255 : stemp + 10;
        lo   = (stemp - 10 < 0) ? 0 : stemp - 10;
        act  = (m_mode == ML || m_mode == MS || m_mode == MH);
        band = (m_mode == MS || m_mode == MH);
        if (sp) begin
            m_mode = MI; m_loaded = 0; m_inband = 0;
        end else if (act && temp >= 250) begin
            m_mode = MF;
        end else if (band && m_inband + 1 == m_loaded * DIV) begin
            m_inband++;
            m_mode = MD;
        end else if ((m_mode == MI || m_mode == MD) && st && stime != 0) begin
            m_mode = ML; m_loaded = stime; m_inband = 0;
        end else begin
            if (band) m_inband++;
            if (m_mode == ML && temp > lo)                    m_mode = MS;
            else if (m_mode == MS && temp >= up)             m_mode = MH;
            else if (m_mode == MS && temp <= lo)             m_mode = ML;
            else if (m_mode == MH && temp < up)              m_mode = MS;
        end
    endfunction

    initial begin
        int stemp, temp;
        logic st, sp;
        int stime;

        add(1, 1, 0,  50, 100, 3, ML, 3);
        add(1, 0, 0,  50, 100, 3, ML, 3);
        add(1, 0, 0,  95, 100, 3, MS, 3);
        add(3, 0, 0, 100, 100, 3, MS, 3);
        add(4, 0, 0, 100, 100, 3, MS, 2);
        add(4, 0, 0, 100, 100, 3, MS, 1);
        add(2, 0, 0, 100, 100, 3, MD, 0);
        add(1, 1, 0, 100, 100, 3, ML, 3);
        add(4, 0, 0, 100, 100, 3, MS, 3);
        add(2, 0, 0, 100, 100, 3, MS, 2);
        add(3, 0, 0,  85, 100, 3, ML, 2);
        add(2, 0, 0, 100, 100, 3, MS, 2);
        add(1, 0, 0, 100, 100, 3, MS, 1);
        add(1, 0, 0, 115, 100, 3, MH, 1);
        add(1, 0, 0, 255, 100, 3, MF, 1);
        add(1, 1, 0,  50, 100, 3, MF, 1);
        add(1, 0, 1,  50, 100, 3, MI, 0);
        add(1, 1, 1,  50, 100, 3, MI, 0);
        add(1, 0, 0,  50, 100, 3, MI, 0);
        add(1, 1, 0,   0,   5, 2, ML, 2);
        add(1, 0, 0,   0,   5, 2, ML, 2);
        add(1, 0, 0,   1,   5, 2, MS, 2);
        add(1, 0, 0, 249, 250, 2, MS, 2);
        add(1, 0, 1, 249, 250, 2, MI, 0);
        add(1, 1, 0,  50, 100, 0, MI, 0);

        #1 check("reset_state", exp_out(MI, 0, 1'b0, 0));
        @(negedge clk) rst_n = 1'b1;

        foreach (tv[i]) begin
            if (i != 0) @(negedge clk);
            drive(tv[i].st, tv[i].sp, tv[i].temp, tv[i].stemp, tv[i].stime);
            @(posedge clk) #1;
            check($sformatf("vec%0d", i),
                  exp_out(tv[i].mode, tv[i].tl, tv[i].sp, tv[i].temp));
        end

        // Asynchronous reset in the middle of a SET phase
        @(negedge clk) drive(1, 0, 100, 100, 5);
        @(negedge clk) drive(0, 0, 100, 100, 5);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_reset", exp_out(MI, 0, 1'b0, 100));
        @(negedge clk) rst_n = 1'b1;
        #1 check("post_reset_idle", exp_out(MI, 0, 1'b0, 100));
        @(negedge clk) drive(1, 0, 50, 100, 5);
        @(posedge clk) #1 check("first_edge_start", exp_out(ML, 5, 1'b0, 50));
        @(negedge clk) drive(0, 0, 100, 100, 5);
        @(posedge clk) #1 check("fresh_set", exp_out(MS, 5, 1'b0, 100));

        // Randomized run against the model
        stemp = 100;
        temp  = 100;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 199) == 0) stemp = $urandom_range(0, 255);
            if ($urandom_range(0, 99) < 30) begin
                if ($urandom_range(0, 99) < 3)
                    temp = $urandom_range(240, 255);
                else begin
                    temp = stemp + int'($urandom_range(0, 40)) - 20;
                    if (temp < 0)   temp = 0;
                    if (temp > 255) temp = 255;
                end
            end
            sp    = (i == 0) || ($urandom_range(0, 99) < 3);
            st    = ($urandom_range(0, 99) < 10);
            stime = $urandom_range(0, 6);
            drive(st, sp, temp, stemp, stime);
            #1;
            if (i != 0)
                check($sformatf("rand%0d", i),
                      exp_out(m_mode, m_tl(), sp, temp));
            m_step(st, sp, temp, stemp, stime);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
